// File: rtl/tr_pkg.sv
// Shared definitions for the tracking-mode controller and its step output stage:
// datapath width, default step timing and the step generator state encoding.
package tr_pkg;

  localparam int WIDTH_WORK = 16;
  localparam int PULSE_W    = 50;
  localparam int MIN_PERIOD = 100;
  localparam int DIR_SETUP  = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } step_state_t;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchronizer.
// Bits are not resynchronised as a word, so wide inputs must be held stable.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture of the asynchronous input word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r <= {W{1'b0}};
      sync_r <= {W{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR/EN generator for the external stepper driver: fixed-width pulses,
// period taken from the controller's word, with DIR setup and a signed position count.
import tr_pkg::*;

module step_pulse_gen #(
  parameter int WIDTH_WORK = tr_pkg::WIDTH_WORK,
  parameter int PULSE_W    = tr_pkg::PULSE_W,
  parameter int MIN_PERIOD = tr_pkg::MIN_PERIOD,
  parameter int DIR_SETUP  = tr_pkg::DIR_SETUP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_WORK-1:0] n,
  input  logic                  drv_dir,
  input  logic                  drv_en_SM,
  output logic                  step,
  output logic                  dir,
  output logic                  en,
  output logic                  busy,
  output logic [WIDTH_WORK-1:0] pos
);

  localparam logic [WIDTH_WORK-1:0] ZERO       = {WIDTH_WORK{1'b0}};
  localparam logic [WIDTH_WORK-1:0] ONE        = WIDTH_WORK'(1);
  localparam logic [WIDTH_WORK-1:0] MIN_P      = WIDTH_WORK'(MIN_PERIOD);
  localparam logic [WIDTH_WORK-1:0] PULSE_P    = WIDTH_WORK'(PULSE_W);
  localparam logic [WIDTH_WORK-1:0] PULSE_LAST = WIDTH_WORK'(PULSE_W - 1);
  localparam logic [WIDTH_WORK-1:0] SETUP_LAST = WIDTH_WORK'(DIR_SETUP - 1);

  logic [WIDTH_WORK+1:0] sync_in_s;
  logic [WIDTH_WORK+1:0] sync_out_s;
  logic [WIDTH_WORK-1:0] n_s;
  logic                  dir_s;
  logic                  en_s;

  logic [WIDTH_WORK-1:0] per_new_s;
  logic [WIDTH_WORK-1:0] low_last_s;

  step_state_t           state_r;
  logic [WIDTH_WORK-1:0] cnt_r;
  logic [WIDTH_WORK-1:0] per_r;
  logic [WIDTH_WORK-1:0] pos_r;
  logic                  step_r;
  logic                  dir_r;
  logic                  en_r;
  logic                  busy_r;

  function automatic logic [WIDTH_WORK-1:0] pos_step(input logic [WIDTH_WORK-1:0] p,
                                                      input logic up);
    if (up) begin
      return p + ONE;
    end else begin
      return p - ONE;
    end
  endfunction

  assign sync_in_s = {n, drv_dir, drv_en_SM};

  sync2 #(
    .W (WIDTH_WORK + 2)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in_s),
    .q   (sync_out_s)
  );

  assign n_s   = sync_out_s[WIDTH_WORK+1:2];
  assign dir_s = sync_out_s[1];
  assign en_s  = sync_out_s[0];

  // Period clamp and the LOW terminal count derived from the latched period.
  always_comb begin
    per_new_s  = n_s;
    low_last_s = per_r - PULSE_P - ONE;
    if (n_s < MIN_P) begin
      per_new_s = MIN_P;
    end else begin
      per_new_s = n_s;
    end
  end

  // Step sequencer: every pulse runs its full width and every period runs to its end
  // before enable, period or direction changes are honoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= ZERO;
      per_r   <= ZERO;
      pos_r   <= ZERO;
      step_r  <= 1'b0;
      dir_r   <= 1'b0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          step_r <= 1'b0;
          en_r   <= en_s;
          cnt_r  <= ZERO;
          if (en_s && (n_s != ZERO)) begin
            busy_r <= 1'b1;
            if (dir_s != dir_r) begin
              dir_r   <= dir_s;
              state_r <= SETUP;
            end else begin
              state_r <= HIGH;
              step_r  <= 1'b1;
              per_r   <= per_new_s;
              pos_r   <= pos_step(pos_r, dir_r);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        SETUP: begin
          if (!en_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            en_r    <= 1'b0;
            cnt_r   <= ZERO;
          end else if (cnt_r == SETUP_LAST) begin
            state_r <= HIGH;
            step_r  <= 1'b1;
            per_r   <= per_new_s;
            pos_r   <= pos_step(pos_r, dir_r);
            cnt_r   <= ZERO;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end

        HIGH: begin
          if (cnt_r == PULSE_LAST) begin
            state_r <= LOW;
            step_r  <= 1'b0;
            cnt_r   <= ZERO;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end

        LOW: begin
          if (cnt_r == low_last_s) begin
            cnt_r <= ZERO;
            if (!en_s || (n_s == ZERO)) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              en_r    <= en_s;
            end else if (dir_s != dir_r) begin
              dir_r   <= dir_s;
              state_r <= SETUP;
            end else begin
              state_r <= HIGH;
              step_r  <= 1'b1;
              per_r   <= per_new_s;
              pos_r   <= pos_step(pos_r, dir_r);
            end
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end

        default: begin
          state_r <= IDLE;
          step_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= ZERO;
        end
      endcase
    end
  end

  assign step = step_r;
  assign dir  = dir_r;
  assign en   = en_r;
  assign busy = busy_r;
  assign pos  = pos_r;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: timing of pulses, clamp, stop, direction
// change, enable drop, async reset, plus position wrap on a narrow, fast instance.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] n = 16'd0;
  logic        drv_dir = 1'b0;
  logic        drv_en_SM = 1'b0;
  logic        step, dir, en, busy;
  logic [15:0] pos;

  logic [7:0]  n_w = 8'd0;
  logic        dir_w = 1'b0;
  logic        en_w = 1'b0;
  logic        step_w, dir_o_w, en_o_w, busy_w;
  logic [7:0]  pos_w;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rise_cnt = 0;
  int last_rise = 0;
  int prev_rise = 0;
  int last_fall = 0;
  int rise_w_cnt = 0;
  logic step_q = 1'b0;
  logic step_w_q = 1'b0;

  always #5 clk = ~clk;

  step_pulse_gen dut (
    .clk       (clk),
    .rst       (rst),
    .n         (n),
    .drv_dir   (drv_dir),
    .drv_en_SM (drv_en_SM),
    .step      (step),
    .dir       (dir),
    .en        (en),
    .busy      (busy),
    .pos       (pos)
  );

  step_pulse_gen #(
    .WIDTH_WORK (8),
    .PULSE_W    (1),
    .MIN_PERIOD (2),
    .DIR_SETUP  (1)
  ) dut_w (
    .clk       (clk),
    .rst       (rst),
    .n         (n_w),
    .drv_dir   (dir_w),
    .drv_en_SM (en_w),
    .step      (step_w),
    .dir       (dir_o_w),
    .en        (en_o_w),
    .busy      (busy_w),
    .pos       (pos_w)
  );

  // Edge recorder: cycle numbers of STEP rises and falls.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (step && !step_q) begin
      rise_cnt  = rise_cnt + 1;
      prev_rise = last_rise;
      last_rise = cyc;
    end
    if (!step && step_q) last_fall = cyc;
    if (step_w && !step_w_q) rise_w_cnt = rise_w_cnt + 1;
    step_q   = step;
    step_w_q = step_w;
  end

  task automatic wait_rise(input int budget, output bit ok);
    int start;
    start = rise_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rise_cnt != start) break;
    end
    ok = (rise_cnt != start);
  endtask

  task automatic wait_fall(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!step) break;
    end
    ok = !step;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({step, dir, en, busy} !== 4'b0000) begin errors++; $display("FAIL reset_pins: got %b want 0000", {step, dir, en, busy}); end
    checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL reset_pos: got %h want 0000", pos); end
    checks++; if (pos_w !== 8'h00) begin errors++; $display("FAIL reset_pos_w: got %h want 00", pos_w); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int c0;
    bit ok;
    c0 = cyc;
    n = 16'd200; drv_dir = 1'b0; drv_en_SM = 1'b1;
    wait_rise(20, ok);
    checks++; if (!ok || last_rise != c0 + 3) begin errors++; $display("FAIL first_rise: got cycle %0d want %0d", last_rise, c0 + 3); end
    checks++; if (pos !== 16'hFFFF) begin errors++; $display("FAIL basic_pos1: got %h want ffff", pos); end
    checks++; if ({en, busy, dir} !== 3'b110) begin errors++; $display("FAIL basic_pins: got %b want 110", {en, busy, dir}); end
    wait_fall(100, ok);
    checks++; if (!ok || last_fall - last_rise != 50) begin errors++; $display("FAIL basic_width: got %0d want 50", last_fall - last_rise); end
    wait_rise(300, ok);
    checks++; if (!ok || last_rise - prev_rise != 200) begin errors++; $display("FAIL basic_period: got %0d want 200", last_rise - prev_rise); end
    checks++; if (pos !== 16'hFFFE) begin errors++; $display("FAIL basic_pos2: got %h want fffe", pos); end
  endtask

  task automatic test_clamp;
    bit ok;
    n = 16'd40;
    wait_rise(300, ok);
    checks++; if (!ok || last_rise - prev_rise != 200) begin errors++; $display("FAIL clamp_defer: got %0d want 200", last_rise - prev_rise); end
    wait_rise(300, ok);
    checks++; if (!ok || last_rise - prev_rise != 100) begin errors++; $display("FAIL clamp_period: got %0d want 100", last_rise - prev_rise); end
    wait_fall(100, ok);
    checks++; if (!ok || last_fall - last_rise != 50) begin errors++; $display("FAIL clamp_width: got %0d want 50", last_fall - last_rise); end
  endtask

  task automatic test_stop;
    int r;
    bit ok;
    r = last_rise;
    wait_cyc(r + 60);
    n = 16'd0;
    wait_cyc(r + 99);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_hold: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_drop: got %b want 0", busy); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL stop_en: got %b want 1", en); end
    wait_rise(300, ok);
    checks++; if (ok) begin errors++; $display("FAIL stop_no_pulse: got rise at %0d want none", last_rise); end
    checks++; if (pos !== 16'hFFFC) begin errors++; $display("FAIL stop_pos: got %h want fffc", pos); end
  endtask

  task automatic test_dir_change;
    int c0, r;
    bit ok;
    c0 = cyc;
    n = 16'd200;
    wait_rise(20, ok);
    checks++; if (!ok || last_rise != c0 + 3) begin errors++; $display("FAIL restart_rise: got cycle %0d want %0d", last_rise, c0 + 3); end
    r = last_rise;
    wait_cyc(r + 10);
    drv_dir = 1'b1;
    wait_fall(100, ok);
    checks++; if (!ok || last_fall - r != 50) begin errors++; $display("FAIL dir_width: got %0d want 50", last_fall - r); end
    wait_cyc(r + 199);
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL dir_hold: got %b want 0", dir); end
    @(negedge clk);
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL dir_edge: got %b want 1", dir); end
    wait_rise(60, ok);
    checks++; if (!ok || last_rise - (r + 200) != 25) begin errors++; $display("FAIL dir_setup: got %0d want 25", last_rise - (r + 200)); end
    checks++; if (pos !== 16'hFFFC) begin errors++; $display("FAIL dir_pos1: got %h want fffc", pos); end
    wait_rise(300, ok);
    checks++; if (!ok || last_rise - prev_rise != 200) begin errors++; $display("FAIL dir_period: got %0d want 200", last_rise - prev_rise); end
    checks++; if (pos !== 16'hFFFD) begin errors++; $display("FAIL dir_pos2: got %h want fffd", pos); end
  endtask

  task automatic test_enable_drop;
    int r;
    bit ok;
    r = last_rise;
    wait_cyc(r + 10);
    drv_en_SM = 1'b0;
    wait_fall(100, ok);
    checks++; if (!ok || last_fall - r != 50) begin errors++; $display("FAIL endrop_width: got %0d want 50", last_fall - r); end
    wait_cyc(r + 199);
    checks++; if ({en, busy} !== 2'b11) begin errors++; $display("FAIL endrop_hold: got %b want 11", {en, busy}); end
    @(negedge clk);
    checks++; if ({en, busy} !== 2'b00) begin errors++; $display("FAIL endrop_idle: got %b want 00", {en, busy}); end
    wait_rise(300, ok);
    checks++; if (ok) begin errors++; $display("FAIL endrop_no_pulse: got rise at %0d want none", last_rise); end
    checks++; if (pos !== 16'hFFFD) begin errors++; $display("FAIL endrop_pos: got %h want fffd", pos); end
  endtask

  task automatic test_async_reset;
    int r;
    bit ok;
    drv_en_SM = 1'b1;
    wait_rise(20, ok);
    checks++; if (!ok || pos !== 16'hFFFE) begin errors++; $display("FAIL arst_pre_pos: got %h want fffe", pos); end
    r = last_rise;
    wait_cyc(r + 10);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL arst_pre_step: got %b want 1", step); end
    rst = 1'b0;
    #1;
    checks++; if ({step, busy, en, dir} !== 4'b0000) begin errors++; $display("FAIL arst_pins: got %b want 0000", {step, busy, en, dir}); end
    checks++; if (pos !== 16'h0000) begin errors++; $display("FAIL arst_pos: got %h want 0000", pos); end
    drv_en_SM = 1'b0; n = 16'd0; drv_dir = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int base;
    bit hit;
    base = rise_w_cnt;
    n_w = 8'd2; dir_w = 1'b1; en_w = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (rise_w_cnt - base == 256) begin hit = 1'b1; break; end
    end
    checks++; if (!hit || pos_w !== 8'h00) begin errors++; $display("FAIL wrap_256: got %h want 00", pos_w); end
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rise_w_cnt - base == 259) begin hit = 1'b1; break; end
    end
    checks++; if (!hit || pos_w !== 8'h03) begin errors++; $display("FAIL wrap_259: got %h want 03", pos_w); end
    en_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stop();
    test_dir_change();
    test_enable_drop();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
